// File: rtl/door_pkg.sv
// Shared types for the door controller: state encodings and travel direction constants.
package door_pkg;

   typedef enum logic [2:0] {
      ST_CLOSED  = 3'd0,
      ST_OPENING = 3'd1,
      ST_OPEN    = 3'd2,
      ST_CLOSING = 3'd3,
      ST_STOPPED = 3'd4,
      ST_FAULT   = 3'd5
   } door_state_e;

   localparam logic UP = 1'b1;
   localparam logic DN = 1'b0;

endpackage

// File: rtl/door_timer.sv
// Saturating up-counter measuring cycles spent in the current door state.
module door_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk_sys,
   input  logic             rst_b,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/door_ctrl_gen2.sv
// Garage-door sequencer with travel timeout and sensor-conflict fault.
// Optional auto-close from OPEN is compiled in with DOOR_AUTO_CLOSE_EN.
//
// state   | meaning
// CLOSED  | at lower limit, motors off
// OPENING | driving up
// OPEN    | at upper limit, motors off
// CLOSING | driving down
// STOPPED | halted mid-travel, next activate reverses last direction
// FAULT   | travel timeout or limit conflict, waits for fault_clr
module door_ctrl_gen2
   import door_pkg::*;
#(
   parameter int TRAVEL_MAX = 1000,
   parameter int AUTO_CLOSE = 5000,
   parameter int CNT_W      = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       activate,
   input  logic       UP_Max,
   input  logic       DN_Max,
   input  logic       obstacle,
   input  logic       fault_clr,
   output logic       UP_M,
   output logic       DN_M,
   output logic [2:0] state_o,
   output logic       fault
);

`ifdef DOOR_AUTO_CLOSE_EN
   localparam logic AUTO_CLOSE_ON = 1'b1;
`else
   localparam logic AUTO_CLOSE_ON = 1'b0;
`endif

   localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(AUTO_CLOSE - 1);

   door_state_e      state_q;
   door_state_e      state_d;
   logic             last_dir_q;
   logic             last_dir_d;
   logic             act_q;
   logic             act_rise;
   logic [CNT_W-1:0] timer;
   logic             travel_done;
   logic             dwell_done;

   // Timer restarts on the edge that enters a new state, so it counts cycles spent in it.
   door_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk_sys (CLK),
      .rst_b   (RST),
      .clr     (state_d != state_q),
      .en      (1'b1),
      .cnt     (timer)
   );

   assign act_rise    = activate & ~act_q;
   assign travel_done = (timer == TRAVEL_LAST);
   assign dwell_done  = AUTO_CLOSE_ON & (timer == DWELL_LAST);

   always_comb begin
      state_d    = state_q;
      last_dir_d = last_dir_q;
      if (UP_Max && DN_Max && (state_q != ST_FAULT)) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_CLOSED: begin
               if (act_rise) state_d = ST_OPENING;
            end
            ST_OPENING: begin
               if (UP_Max) begin
                  state_d = ST_OPEN;
               end else if (travel_done) begin
                  state_d = ST_FAULT;
               end else if (act_rise) begin
                  state_d    = ST_STOPPED;
                  last_dir_d = UP;
               end
            end
            ST_OPEN: begin
               if (act_rise || dwell_done) state_d = ST_CLOSING;
            end
            ST_CLOSING: begin
               if (DN_Max) begin
                  state_d = ST_CLOSED;
               end else if (obstacle) begin
                  state_d = ST_OPENING;
               end else if (travel_done) begin
                  state_d = ST_FAULT;
               end else if (act_rise) begin
                  state_d    = ST_STOPPED;
                  last_dir_d = DN;
               end
            end
            ST_STOPPED: begin
               if (act_rise) state_d = (last_dir_q == UP) ? ST_CLOSING : ST_OPENING;
            end
            ST_FAULT: begin
               if (fault_clr) begin
                  state_d    = ST_STOPPED;
                  last_dir_d = DN;
               end
            end
            default: begin
               state_d = ST_STOPPED;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= ST_STOPPED;
         last_dir_q <= DN;
         act_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_dir_q <= last_dir_d;
         act_q      <= activate;
      end
   end

   always_comb begin
      UP_M    = (state_q == ST_OPENING);
      DN_M    = (state_q == ST_CLOSING);
      fault   = (state_q == ST_FAULT);
      state_o = state_q;
   end

endmodule

// File: tb/tb_door_ctrl_gen2.sv
// Bench for door_ctrl_gen2: directed scenarios plus randomized traffic against a behavioural model.
// Honours DOOR_AUTO_CLOSE_EN the same way as the design.
module tb_door_ctrl_gen2;
   import door_pkg::*;

   localparam int TM = 20;
   localparam int AC = 30;
   localparam int CW = 16;
   localparam int SAT = (1 << CW) - 1;

   localparam int M_CLOSED  = 0;
   localparam int M_OPENING = 1;
   localparam int M_OPEN    = 2;
   localparam int M_CLOSING = 3;
   localparam int M_STOPPED = 4;
   localparam int M_FAULT   = 5;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       activate = 1'b0;
   logic       UP_Max = 1'b0;
   logic       DN_Max = 1'b0;
   logic       obstacle = 1'b0;
   logic       fault_clr = 1'b0;
   logic       UP_M;
   logic       DN_M;
   logic       fault;
   logic [2:0] state_o;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   door_ctrl_gen2 #(
      .TRAVEL_MAX (TM),
      .AUTO_CLOSE (AC),
      .CNT_W      (CW)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .activate  (activate),
      .UP_Max    (UP_Max),
      .DN_Max    (DN_Max),
      .obstacle  (obstacle),
      .fault_clr (fault_clr),
      .UP_M      (UP_M),
      .DN_M      (DN_M),
      .state_o   (state_o),
      .fault     (fault)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int code_of(input int m);
      case (m)
         M_CLOSED:  return int'(ST_CLOSED);
         M_OPENING: return int'(ST_OPENING);
         M_OPEN:    return int'(ST_OPEN);
         M_CLOSING: return int'(ST_CLOSING);
         M_STOPPED: return int'(ST_STOPPED);
         default:   return int'(ST_FAULT);
      endcase
   endfunction

   // Reference model: state, cycles spent in it, last travel direction, previous activate level.
   int m_st      = M_STOPPED;
   int m_dwell   = 0;
   bit m_last_up = 1'b0;
   bit m_prev    = 1'b0;

   always @(posedge CLK) begin : model
      int nx;
      bit rise;
      if (!RST) begin
         m_st = M_STOPPED; m_dwell = 0; m_last_up = 1'b0; m_prev = 1'b0;
      end else begin
         rise = activate && !m_prev;
         nx = m_st;
         if (UP_Max && DN_Max && m_st != M_FAULT) nx = M_FAULT;
         else if (m_st == M_CLOSED && rise) nx = M_OPENING;
         else if (m_st == M_OPENING) begin
            if (UP_Max) nx = M_OPEN;
            else if (m_dwell == TM - 1) nx = M_FAULT;
            else if (rise) begin nx = M_STOPPED; m_last_up = 1'b1; end
         end else if (m_st == M_CLOSING) begin
            if (DN_Max) nx = M_CLOSED;
            else if (obstacle) nx = M_OPENING;
            else if (m_dwell == TM - 1) nx = M_FAULT;
            else if (rise) begin nx = M_STOPPED; m_last_up = 1'b0; end
         end else if (m_st == M_OPEN) begin
            if (rise) nx = M_CLOSING;
`ifdef DOOR_AUTO_CLOSE_EN
            if (m_dwell == AC - 1) nx = M_CLOSING;
`endif
         end else if (m_st == M_STOPPED && rise) nx = m_last_up ? M_CLOSING : M_OPENING;
         else if (m_st == M_FAULT && fault_clr) begin nx = M_STOPPED; m_last_up = 1'b0; end
         m_dwell = (nx != m_st) ? 0 : ((m_dwell < SAT) ? m_dwell + 1 : SAT);
         m_st = nx;
         m_prev = activate;
      end
   end

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("state", int'(state_o), code_of(m_st));
         chk("up_m", int'(UP_M), int'(m_st == M_OPENING));
         chk("dn_m", int'(DN_M), int'(m_st == M_CLOSING));
         chk("fault", int'(fault), int'(m_st == M_FAULT));
         chk("motor_excl", int'(UP_M & DN_M), 0);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      int changes;
      logic [2:0] prev;

      RST = 1'b0;
      tick();
      cmp_en = 1'b1;
      tick(); tick();
      chk("rst_state", int'(state_o), int'(ST_STOPPED));
      chk("rst_outputs", int'({UP_M, DN_M, fault}), 0);

      // open with activate pulse, upper limit during cycle 8
      RST = 1'b1; activate = 1'b1;
      tick();
      activate = 1'b0;
      n = int'(UP_M);
      repeat (7) begin tick(); n += int'(UP_M); end
      UP_Max = 1'b1;
      tick();
      chk("up_cycles", n, 8);
      chk("open_state", int'(state_o), int'(ST_OPEN));
      chk("open_upm", int'(UP_M), 0);
      tick();
      chk("open_upmax_noop", int'(state_o), int'(ST_OPEN));
      UP_Max = 1'b0;

      // close, obstacle in closing cycle 5 reverses
      activate = 1'b1;
      tick();
      activate = 1'b0;
      chk("close_dnm", int'(DN_M), 1);
      repeat (4) tick();
      obstacle = 1'b1;
      tick();
      obstacle = 1'b0;
      chk("rev_state", int'(state_o), int'(ST_OPENING));
      chk("rev_motors", int'({UP_M, DN_M}), 2);

      // travel timeout
      n = 0;
      while (!fault && n < 40) begin tick(); n++; end
      chk("fault_delay", n, 20);
      chk("fault_motors", int'({UP_M, DN_M}), 0);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("fault_clr_state", int'(state_o), int'(ST_STOPPED));
      activate = 1'b1;
      tick();
      activate = 1'b0;
      chk("stopped_to_opening", int'(state_o), int'(ST_OPENING));

      // stop mid-opening, then resume in the opposite direction
      tick(); tick();
      activate = 1'b1;
      tick();
      activate = 1'b0;
      chk("stop_state", int'(state_o), int'(ST_STOPPED));
      tick();
      activate = 1'b1;
      tick();
      activate = 1'b0;
      chk("resume_dnm", int'(DN_M), 1);

      // reach OPEN, then idle
      obstacle = 1'b1; tick(); obstacle = 1'b0;
      UP_Max = 1'b1; tick(); UP_Max = 1'b0;
      chk("idle_open", int'(state_o), int'(ST_OPEN));
`ifdef DOOR_AUTO_CLOSE_EN
      n = 0;
      while (state_o == ST_OPEN && n < 200) begin tick(); n++; end
      chk("auto_close_delay", n, 30);
      chk("auto_close_state", int'(state_o), int'(ST_CLOSING));
`else
      repeat (100) tick();
      chk("open_hold", int'(state_o), int'(ST_OPEN));
      activate = 1'b1; tick(); activate = 1'b0;
      chk("manual_close", int'(state_o), int'(ST_CLOSING));
`endif

      // reset mid-travel stops the motor
      repeat (3) tick();
      RST = 1'b0;
      tick();
      RST = 1'b1;
      chk("rst_mid_dnm", int'(DN_M), 0);
      tick();
      chk("rst_mid_state", int'(state_o), int'(ST_STOPPED));

      // activate held high: one transition only
      activate = 1'b1; tick(); activate = 1'b0; tick();
      activate = 1'b1;
      prev = state_o;
      changes = 0;
      repeat (50) begin
         tick();
         if (state_o != prev) changes++;
         prev = state_o;
      end
      chk("hold_transitions", changes, 1);
      activate = 1'b0; tick();
      activate = 1'b1; tick(); activate = 1'b0;
      DN_Max = 1'b1;
      tick();
      chk("closed_state", int'(state_o), int'(ST_CLOSED));
      tick();
      chk("closed_dnmax_noop", int'(state_o), int'(ST_CLOSED));
      UP_Max = 1'b1;
      tick();
      chk("conflict_fault", int'(fault), 1);
      UP_Max = 1'b0; DN_Max = 1'b0;
      fault_clr = 1'b1; tick(); fault_clr = 1'b0;

      // randomized traffic, checked every cycle by the model compare
      repeat (3000) begin
         activate  = ($urandom_range(0, 3) == 0);
         UP_Max    = ($urandom_range(0, 11) == 0);
         DN_Max    = ($urandom_range(0, 11) == 0);
         obstacle  = ($urandom_range(0, 9) == 0);
         fault_clr = ($urandom_range(0, 7) == 0);
         RST       = ($urandom_range(0, 299) != 0);
         tick();
      end
      RST = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/door_ctrl_gen2.md
DOOR_CTRL_GEN2 -- requirements
Module: door_ctrl_gen2

Interface
REQ-001 The block SHALL have parameter TRAVEL_MAX, default 1000: the maximum number of motor-on cycles allowed per travel before a fault is raised.
REQ-002 The block SHALL have parameter AUTO_CLOSE, default 5000: the number of dwell cycles in OPEN before the door closes automatically.
REQ-003 The block SHALL have parameter CNT_W, default 16: the timer width; it must satisfy 2^CNT_W > max(TRAVEL_MAX, AUTO_CLOSE).
REQ-004 Port CLK: input, 1 bit, the single clock, rising edge.
REQ-005 Port RST: input, 1 bit; reset is synchronous and active-low.
REQ-006 Port activate: input, 1 bit, the user command level; only its rising edge acts.
REQ-007 Ports UP_Max and DN_Max: inputs, 1 bit each, the upper and lower limit switches.
REQ-008 Port obstacle: input, 1 bit, the beam-break sensor.
REQ-009 Port fault_clr: input, 1 bit, the fault acknowledge.
REQ-010 Ports UP_M and DN_M: outputs, 1 bit each, the motor up and motor down drives.
REQ-011 Port state_o: output, 3 bits, the current state encoding.
REQ-012 Port fault: output, 1 bit, high while the controller is in FAULT.

Function
REQ-013 The FSM SHALL have the states CLOSED, OPENING, OPEN, CLOSING, STOPPED and FAULT.
REQ-014 act_rise SHALL be activate high while the registered activate from the previous cycle is low.
REQ-015 Outputs SHALL be Moore-decoded from the registered state:
- UP_M=1 only in OPENING.
- DN_M=1 only in CLOSING.
- fault=1 only in FAULT.
- UP_M and DN_M SHALL never be high together.
REQ-016 Latency: an input sampled at edge k SHALL produce the new state, and its output, immediately after edge k.
REQ-017 When UP_Max and DN_Max are both high, the FSM SHALL go to FAULT from any state other than FAULT; this has the highest priority.
REQ-018 In CLOSED, act_rise SHALL move the FSM to OPENING.
REQ-019 In OPENING, the priority order SHALL be:
- UP_Max moves to OPEN.
- Otherwise, timer == TRAVEL_MAX-1 moves to FAULT.
- Otherwise, act_rise moves to STOPPED and sets last_dir=UP.
REQ-020 In CLOSING, the priority order SHALL be:
- DN_Max moves to CLOSED.
- Otherwise, obstacle moves to OPENING (reverse).
- Otherwise, timer == TRAVEL_MAX-1 moves to FAULT.
- Otherwise, act_rise moves to STOPPED and sets last_dir=DN.
REQ-021 In OPEN, act_rise SHALL move to CLOSING; the auto-close behaviour is defined in REQ-029.
REQ-022 In STOPPED, act_rise SHALL move to CLOSING if last_dir=UP and to OPENING otherwise.
REQ-023 In FAULT, fault_clr SHALL move to STOPPED and set last_dir=DN; all other inputs are ignored.
REQ-024 The timer SHALL clear on every state change, increment by 1 each cycle otherwise, and saturate at all-ones.
REQ-025 UP_Max high while in OPEN, or DN_Max high while in CLOSED, SHALL be a no-op.

Reset
REQ-026 While RST=0 at a rising CLK edge, the block SHALL load:
- state=STOPPED, last_dir=DN.
- timer=0, registered activate=0.
- Outputs UP_M=0, DN_M=0, fault=0, state_o=STOPPED code.
REQ-027 A reset asserted mid-travel SHALL stop the motor from the next edge, with no further travel.

Configuration
REQ-028 Macro DOOR_AUTO_CLOSE_EN SHALL select whether the auto-close feature is compiled in.
REQ-029 With DOOR_AUTO_CLOSE_EN defined:
- In OPEN, timer == AUTO_CLOSE-1 SHALL move the FSM to CLOSING.
- act_rise in the same cycle as expiry also moves to CLOSING.
REQ-030 Without DOOR_AUTO_CLOSE_EN, OPEN SHALL leave only on act_rise or a sensor conflict, and the AUTO_CLOSE parameter is unused.

Structure
REQ-031 Package door_pkg SHALL hold the state enum typedef, its 3-bit encodings, and the direction constants UP and DN.
REQ-032 The saturating timer SHALL be a sub-module door_timer, with parameter CNT_W, inputs clr and en, and output cnt.

Verification
Unless noted, scenarios use TRAVEL_MAX=20 and AUTO_CLOSE=30.
REQ-033 Reset, then an activate pulse, then UP_Max asserted at cycle 8 -> UP_M=1 for cycles 1-8, then state OPEN with UP_M=0.
REQ-034 OPEN, then act_rise, then obstacle at CLOSING cycle 5 -> DN_M falls and UP_M=1 on the next cycle, with state OPENING.
REQ-035 OPENING with no UP_Max -> fault=1 exactly 20 cycles after entry, motors 0; fault_clr then gives STOPPED, and activate gives OPENING.
REQ-036 OPENING, act_rise at cycle 3 (STOPPED), then act_rise -> CLOSING with DN_M=1.
REQ-037 With DOOR_AUTO_CLOSE_EN defined, OPEN idles for 30 cycles -> CLOSING. Without the macro, OPEN holds for 100 cycles.
REQ-038 UP_Max=DN_Max=1 in CLOSED -> FAULT next cycle. Activate held high for 50 cycles gives exactly one transition.
